sdram_cmd_arbiter: RTL and testbench

// Owns the SDRAM command/address pins after power-up. Passes the init sequencer's bus through until

---
 rtl/sdram_cmd_arbiter.sv | 143 ++++++++++++++
 tb/tb_sdram_cmd_arbiter.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_cmd_arbiter.sv
// SDRAM command-pin owner: passes the init sequencer through until init completes, then
// times auto-refresh and grants refresh/write/read sub-blocks one at a time onto the pins.
module sdram_cmd_arbiter #(
   parameter int REF_PERIOD = 780,
   parameter int CNT_W      = 10
) (
   input  logic        sysclk_100M,
   input  logic        rst_n,
   input  logic        init_end_flag,
   input  logic [18:0] init_bus,
   output logic        aref_en,
   input  logic        aref_end,
   input  logic [18:0] aref_bus,
   input  logic        wr_req,
   output logic        wr_en,
   input  logic        wr_end,
   input  logic [18:0] wr_bus,
   input  logic        rd_req,
   output logic        rd_en,
   input  logic        rd_end,
   input  logic [18:0] rd_bus,
   output logic [3:0]  sdram_cmd,
   output logic [1:0]  sdram_ba,
   output logic [12:0] sdram_addr,
   output logic        aref_req
);

   typedef enum logic [2:0] {
      S_INIT,
      S_ARBIT,
      S_AREF,
      S_WRITE,
      S_READ
   } state_t;

   localparam logic [3:0]       CMD_NOP  = 4'b0111;
   localparam logic [CNT_W-1:0] REF_LAST = CNT_W'(REF_PERIOD - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t           state_q, state_d;
   logic [CNT_W-1:0] ref_cnt_q, ref_cnt_d;
   logic             ref_expire;
   logic             aref_req_q, aref_req_d;
   logic             aref_en_q, aref_en_d;
   logic             wr_en_q, wr_en_d;
   logic             rd_en_q, rd_en_d;
   logic [18:0]      pin_bus;

   always_comb begin
      ref_cnt_d  = ref_cnt_q;
      ref_expire = 1'b0;
      if (init_end_flag) begin
         if (ref_cnt_q == REF_LAST) begin
            ref_cnt_d  = '0;
            ref_expire = 1'b1;
         end else begin
            ref_cnt_d = ref_cnt_q + CNT_ONE;
         end
      end
   end

   // A new expiry beats a simultaneous completion; stray aref_end outside S_AREF cannot drop a pending refresh.
   always_comb begin
      aref_req_d = aref_req_q;
      if (ref_expire) begin
         aref_req_d = 1'b1;
      end else if (state_q == S_AREF && aref_end) begin
         aref_req_d = 1'b0;
      end
   end

   always_comb begin
      state_d   = state_q;
      aref_en_d = 1'b0;
      wr_en_d   = 1'b0;
      rd_en_d   = 1'b0;
      case (state_q)
         S_INIT: begin
            if (init_end_flag) state_d = S_ARBIT;
         end
         S_ARBIT: begin
            if (aref_req_q) begin
               state_d   = S_AREF;
               aref_en_d = 1'b1;
            end else if (wr_req) begin
               state_d = S_WRITE;
               wr_en_d = 1'b1;
            end else if (rd_req) begin
               state_d = S_READ;
               rd_en_d = 1'b1;
            end
         end
         S_AREF: begin
            if (aref_end) state_d = S_ARBIT;
         end
         S_WRITE: begin
            if (wr_end) state_d = S_ARBIT;
         end
         S_READ: begin
            if (rd_end) state_d = S_ARBIT;
         end
         default: state_d = S_INIT;
      endcase
   end

   always_ff @(posedge sysclk_100M or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_INIT;
         ref_cnt_q  <= '0;
         aref_req_q <= 1'b0;
         aref_en_q  <= 1'b0;
         wr_en_q    <= 1'b0;
         rd_en_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         ref_cnt_q  <= ref_cnt_d;
         aref_req_q <= aref_req_d;
         aref_en_q  <= aref_en_d;
         wr_en_q    <= wr_en_d;
         rd_en_q    <= rd_en_d;
      end
   end

   // Pins depend only on the registered state, so reset hands them back to init_bus immediately.
   always_comb begin
      case (state_q)
         S_ARBIT: pin_bus = {CMD_NOP, 15'd0};
         S_AREF:  pin_bus = aref_bus;
         S_WRITE: pin_bus = wr_bus;
         S_READ:  pin_bus = rd_bus;
         default: pin_bus = init_bus;
      endcase
   end

   assign sdram_cmd  = pin_bus[18:15];
   assign sdram_ba   = pin_bus[14:13];
   assign sdram_addr = pin_bus[12:0];
   assign aref_en    = aref_en_q;
   assign wr_en      = wr_en_q;
   assign rd_en      = rd_en_q;
   assign aref_req   = aref_req_q;

endmodule

// File: tb/tb_sdram_cmd_arbiter.sv
// Bench for sdram_cmd_arbiter: directed scenarios plus a randomized run, all checked against
// an edge-counting ownership model of the arbiter.
module tb_sdram_cmd_arbiter;

   localparam int RP = 780;
   localparam logic [3:0] NOP = 4'b0111;
   localparam int M_INIT = 0, M_IDLE = 1, M_REF = 2, M_WR = 3, M_RD = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        init_end_flag = 1'b0;
   logic [18:0] init_bus = '0, aref_bus = '0, wr_bus = '0, rd_bus = '0;
   logic        aref_end = 1'b0, wr_req = 1'b0, wr_end = 1'b0, rd_req = 1'b0, rd_end = 1'b0;
   logic        aref_en, wr_en, rd_en, aref_req;
   logic [3:0]  sdram_cmd;
   logic [1:0]  sdram_ba;
   logic [12:0] sdram_addr;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   sdram_cmd_arbiter #(.REF_PERIOD(RP), .CNT_W(10)) dut (
      .sysclk_100M(clk), .rst_n(rst_n), .init_end_flag(init_end_flag), .init_bus(init_bus),
      .aref_en(aref_en), .aref_end(aref_end), .aref_bus(aref_bus),
      .wr_req(wr_req), .wr_en(wr_en), .wr_end(wr_end), .wr_bus(wr_bus),
      .rd_req(rd_req), .rd_en(rd_en), .rd_end(rd_end), .rd_bus(rd_bus),
      .sdram_cmd(sdram_cmd), .sdram_ba(sdram_ba), .sdram_addr(sdram_addr), .aref_req(aref_req)
   );

   // Reference model: who owns the pins, and refresh due whenever the count of
   // flag-high edges since reset reaches a multiple of RP.
   int   m_owner, mn_owner;
   int   m_edges, mn_edges;
   logic m_req, mn_req, m_aen, mn_aen, m_wen, mn_wen, m_ren, mn_ren;
   logic [18:0] m_bus;

   always_comb begin
      mn_owner = m_owner;
      mn_edges = m_edges;
      mn_req   = m_req;
      mn_aen   = 1'b0;
      mn_wen   = 1'b0;
      mn_ren   = 1'b0;
      if (init_end_flag) mn_edges = m_edges + 1;
      if (m_owner == M_INIT) begin
         if (init_end_flag) mn_owner = M_IDLE;
      end else if (m_owner == M_IDLE) begin
         if (m_req) begin mn_owner = M_REF; mn_aen = 1'b1; end
         else if (wr_req) begin mn_owner = M_WR; mn_wen = 1'b1; end
         else if (rd_req) begin mn_owner = M_RD; mn_ren = 1'b1; end
      end else if (m_owner == M_REF && aref_end) mn_owner = M_IDLE;
      else if (m_owner == M_WR && wr_end) mn_owner = M_IDLE;
      else if (m_owner == M_RD && rd_end) mn_owner = M_IDLE;
      if (init_end_flag && (mn_edges % RP) == 0) mn_req = 1'b1;
      else if (m_owner == M_REF && aref_end) mn_req = 1'b0;
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_owner <= M_INIT; m_edges <= 0; m_req <= 1'b0;
         m_aen <= 1'b0; m_wen <= 1'b0; m_ren <= 1'b0;
      end else begin
         m_owner <= mn_owner; m_edges <= mn_edges; m_req <= mn_req;
         m_aen <= mn_aen; m_wen <= mn_wen; m_ren <= mn_ren;
      end
   end

   always_comb begin
      case (m_owner)
         M_INIT:  m_bus = init_bus;
         M_REF:   m_bus = aref_bus;
         M_WR:    m_bus = wr_bus;
         M_RD:    m_bus = rd_bus;
         default: m_bus = {NOP, 15'd0};
      endcase
   end

   logic [18:0] pins;
   logic [22:0] got_vec, exp_vec;
   assign pins    = {sdram_cmd, sdram_ba, sdram_addr};
   assign got_vec = {aref_en, wr_en, rd_en, aref_req, pins};
   assign exp_vec = {m_aen, m_wen, m_ren, m_req, m_bus};

   task automatic randomize_buses();
      init_bus = 19'($urandom);
      aref_bus = 19'($urandom);
      wr_bus   = 19'($urandom);
      rd_bus   = 19'($urandom);
   endtask

   task automatic test_reset();
      randomize_buses();
      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      total++;
      if (got_vec !== {4'b0000, init_bus}) begin
         bad++; $display("FAIL reset_state got=%h want=%h", got_vec, {4'b0000, init_bus});
      end
      randomize_buses();
      #1;
      total++;
      if (pins !== init_bus) begin
         bad++; $display("FAIL reset_pins_follow got=%h want=%h", pins, init_bus);
      end
   endtask

   task automatic test_init_refresh();
      int k_req = 0;
      int k_en = 0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 50; c++) begin
         randomize_buses();
         wr_req = 1'($urandom); rd_req = 1'($urandom);
         wr_end = 1'($urandom); rd_end = 1'($urandom); aref_end = 1'($urandom);
         @(negedge clk);
         total++;
         if (got_vec !== {4'b0000, init_bus}) begin
            bad++; $display("FAIL init_passthru got=%h want=%h", got_vec, {4'b0000, init_bus});
         end
      end
      wr_req = 0; rd_req = 0; wr_end = 0; rd_end = 0; aref_end = 0;
      init_end_flag = 1'b1;
      for (int k = 1; k <= 900 && k_en == 0; k++) begin
         @(negedge clk);
         total++;
         if (got_vec !== exp_vec) begin
            bad++; $display("FAIL pre_refresh got=%h want=%h", got_vec, exp_vec);
         end
         if (k == 1) begin
            total++;
            if (sdram_cmd !== NOP) begin
               bad++; $display("FAIL arbit_nop got=%h want=%h", sdram_cmd, NOP);
            end
         end
         if (aref_req === 1'b1 && k_req == 0) k_req = k;
         if (aref_en === 1'b1) k_en = k;
         if (k_en == 0) randomize_buses();
      end
      total++;
      if (k_req != RP) begin
         bad++; $display("FAIL ref_req_time got=%0d want=%0d", k_req, RP);
      end
      total++;
      if (k_en != RP + 1) begin
         bad++; $display("FAIL ref_en_time got=%0d want=%0d", k_en, RP + 1);
      end
      for (int i = 0; i < 3; i++) begin
         total++;
         if ({aref_en, pins} !== {(i == 0), aref_bus}) begin
            bad++; $display("FAIL aref_pins got=%h want=%h", {aref_en, pins}, {(i == 0), aref_bus});
         end
         randomize_buses();
         @(negedge clk);
      end
      aref_end = 1'b1;
      @(negedge clk);
      aref_end = 1'b0;
      total++;
      if ({aref_req, sdram_cmd} !== {1'b0, NOP} || got_vec !== exp_vec) begin
         bad++; $display("FAIL aref_done got=%h want=%h", got_vec, {4'b0000, NOP, 15'd0});
      end
   endtask

   task automatic test_wr_rd_priority();
      wr_req = 1'b1; rd_req = 1'b1;
      randomize_buses();
      @(negedge clk);
      total++;
      if ({aref_en, wr_en, rd_en, pins} !== {3'b010, wr_bus} || got_vec !== exp_vec) begin
         bad++; $display("FAIL wr_first got=%h want=%h", got_vec, {4'b0100, wr_bus});
      end
      wr_req = 1'b0;
      repeat (3) begin
         randomize_buses();
         @(negedge clk);
         total++;
         if ({wr_en, pins} !== {1'b0, wr_bus}) begin
            bad++; $display("FAIL wr_hold got=%h want=%h", {wr_en, pins}, {1'b0, wr_bus});
         end
      end
      wr_end = 1'b1;
      @(negedge clk);
      wr_end = 1'b0;
      total++;
      if ({rd_en, pins} !== {1'b0, NOP, 15'd0}) begin
         bad++; $display("FAIL wr_turnaround got=%h want=%h", {rd_en, pins}, {1'b0, NOP, 15'd0});
      end
      @(negedge clk);
      total++;
      if ({rd_en, pins} !== {1'b1, rd_bus} || got_vec !== exp_vec) begin
         bad++; $display("FAIL rd_after_wr got=%h want=%h", got_vec, {4'b0010, rd_bus});
      end
      rd_req = 1'b0;
      @(negedge clk);
      rd_end = 1'b1;
      @(negedge clk);
      rd_end = 1'b0;
      total++;
      if (pins !== {NOP, 15'd0} || got_vec !== exp_vec) begin
         bad++; $display("FAIL rd_done got=%h want=%h", got_vec, exp_vec);
      end
   endtask

   task automatic test_ignore_end();
      wr_req = 1'b1;
      @(negedge clk);
      wr_req = 1'b0;
      aref_end = 1'b1; rd_end = 1'b1;
      randomize_buses();
      @(negedge clk);
      aref_end = 1'b0; rd_end = 1'b0;
      total++;
      if ({wr_en, rd_en, aref_en, pins} !== {3'b000, wr_bus} || got_vec !== exp_vec) begin
         bad++; $display("FAIL ignore_other_end got=%h want=%h", {wr_en, rd_en, aref_en, pins}, {3'b000, wr_bus});
      end
      wr_end = 1'b1;
      @(negedge clk);
      wr_end = 1'b0;
      total++;
      if (pins !== {NOP, 15'd0}) begin
         bad++; $display("FAIL ignore_exit got=%h want=%h", pins, {NOP, 15'd0});
      end
   endtask

   task automatic test_refresh_mid_write();
      int waited = 0;
      wr_req = 1'b1; rd_req = 1'b1;
      @(negedge clk);
      wr_req = 1'b0;
      while (aref_req !== 1'b1 && waited < 800) begin
         randomize_buses();
         @(negedge clk);
         waited++;
         total++;
         if (got_vec !== exp_vec) begin
            bad++; $display("FAIL mid_write got=%h want=%h", got_vec, exp_vec);
         end
      end
      total++;
      if (aref_req !== 1'b1 || pins !== wr_bus) begin
         bad++; $display("FAIL ref_during_write got=%h want=%h", {aref_req, pins}, {1'b1, wr_bus});
      end
      wr_end = 1'b1;
      @(negedge clk);
      wr_end = 1'b0;
      @(negedge clk);
      total++;
      if ({aref_en, rd_en, pins} !== {2'b10, aref_bus}) begin
         bad++; $display("FAIL ref_before_rd got=%h want=%h", {aref_en, rd_en, pins}, {2'b10, aref_bus});
      end
      aref_end = 1'b1;
      @(negedge clk);
      aref_end = 1'b0;
      @(negedge clk);
      total++;
      if ({aref_en, rd_en, aref_req, pins} !== {3'b010, rd_bus} || got_vec !== exp_vec) begin
         bad++; $display("FAIL rd_after_ref got=%h want=%h", got_vec, {4'b0010, rd_bus});
      end
      rd_req = 1'b0;
      rd_end = 1'b1;
      @(negedge clk);
      rd_end = 1'b0;
   endtask

   task automatic test_mid_reset();
      rd_req = 1'b1;
      @(negedge clk);
      total++;
      if (rd_en !== 1'b1 || got_vec !== exp_vec) begin
         bad++; $display("FAIL rd_grant got=%h want=%h", got_vec, exp_vec);
      end
      wr_req = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      total++;
      if (got_vec !== {4'b0000, init_bus}) begin
         bad++; $display("FAIL async_reset got=%h want=%h", got_vec, {4'b0000, init_bus});
      end
      init_end_flag = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 20; c++) begin
         randomize_buses();
         @(negedge clk);
         total++;
         if (got_vec !== {4'b0000, init_bus}) begin
            bad++; $display("FAIL no_grant_before_init got=%h want=%h", got_vec, {4'b0000, init_bus});
         end
      end
      init_end_flag = 1'b1;
      @(negedge clk);
      total++;
      if (pins !== {NOP, 15'd0}) begin
         bad++; $display("FAIL reinit_arbit got=%h want=%h", pins, {NOP, 15'd0});
      end
      @(negedge clk);
      total++;
      if ({wr_en, rd_en, pins} !== {2'b10, wr_bus} || got_vec !== exp_vec) begin
         bad++; $display("FAIL reinit_wr_grant got=%h want=%h", got_vec, {4'b0100, wr_bus});
      end
      wr_req = 1'b0; rd_req = 1'b0;
      wr_end = 1'b1;
      @(negedge clk);
      wr_end = 1'b0;
   endtask

   task automatic test_random();
      int a_cnt = 0, w_cnt = 0, r_cnt = 0;
      for (int c = 0; c < 6000; c++) begin
         @(negedge clk);
         total++;
         if (got_vec !== exp_vec) begin
            bad++; $display("FAIL random cyc=%0d got=%h want=%h", c, got_vec, exp_vec);
         end
         randomize_buses();
         aref_end = 1'b0; wr_end = 1'b0; rd_end = 1'b0;
         if (wr_en === 1'b1) wr_req = 1'b0;
         else if (!wr_req && $urandom_range(0, 9) == 0) wr_req = 1'b1;
         if (rd_en === 1'b1) rd_req = 1'b0;
         else if (!rd_req && $urandom_range(0, 5) == 0) rd_req = 1'b1;
         if (aref_en === 1'b1) begin
            a_cnt = $urandom_range(0, 5);
            if (a_cnt == 0) aref_end = 1'b1;
         end else if (a_cnt > 0) begin
            a_cnt--;
            if (a_cnt == 0) aref_end = 1'b1;
         end
         if (wr_en === 1'b1) begin
            w_cnt = $urandom_range(0, 8);
            if (w_cnt == 0) wr_end = 1'b1;
         end else if (w_cnt > 0) begin
            w_cnt--;
            if (w_cnt == 0) wr_end = 1'b1;
         end else if ($urandom_range(0, 15) == 0) wr_end = 1'b1;
         if (rd_en === 1'b1) begin
            r_cnt = $urandom_range(0, 8);
            if (r_cnt == 0) rd_end = 1'b1;
         end else if (r_cnt > 0) begin
            r_cnt--;
            if (r_cnt == 0) rd_end = 1'b1;
         end else if ($urandom_range(0, 15) == 0) rd_end = 1'b1;
      end
   endtask

   initial begin
      test_reset();
      test_init_refresh();
      test_wr_rd_priority();
      test_ignore_end();
      test_refresh_mid_write();
      test_mid_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
